apb_cfg_slave: RTL and testbench

APB_CFG_SLAVE -- requirements
Module: apb_cfg_slave

---
 rtl/apb_cfg_slave.sv | 94 +++++++++
 tb/tb_apb_cfg_slave.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_slave.sv
// apb_cfg_slave: APB configuration completer with wait states, CTRL/STATUS registers
// and double-buffered filter coefficients (shadow bank written over APB, active bank seen by the filter).
module apb_cfg_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_COEF    = 16,
  parameter int COEF_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_WIDTH-1:0]       PADDR,
  input  logic [DATA_WIDTH-1:0]       PWDATA,
  output logic [DATA_WIDTH-1:0]       PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        filt_en,
  output logic                        bypass,
  input  logic [$clog2(NUM_COEF)-1:0] coef_raddr,
  output logic [COEF_W-1:0]           coef_rdata,
  output logic                        coef_update
);
  localparam int IW = $clog2(NUM_COEF);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic [COEF_W-1:0] shadow [NUM_COEF];
  logic [COEF_W-1:0] active [NUM_COEF];
  logic [7:0] commit_cnt;
  logic err_sticky, commit_pend;
  logic [11:0] off, coef_off;
  logic [IW-1:0] coef_idx;
  logic is_ctrl, is_stat, is_coef, err, wr_ok, unused;
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    off        = PADDR[11:0];
    coef_off   = off - 12'h040;
    coef_idx   = coef_off[IW+1:2];
    is_ctrl    = off == 12'h000;
    is_stat    = off == 12'h004;
    is_coef    = off[1:0] == 2'b00 && off >= 12'h040 && int'(coef_off) < 4 * NUM_COEF;
    err        = (PADDR >> 12) != '0 || !(is_ctrl || is_stat || is_coef);
    PREADY     = state == WAIT && wait_cnt == 4'd0 && PSEL && PENABLE;
    PSLVERR    = PREADY && err;
    wr_ok      = PREADY && PWRITE && !err;
    rdata      = is_ctrl ? DATA_WIDTH'({bypass, filt_en}) :
                 is_stat ? DATA_WIDTH'({err_sticky, commit_cnt}) :
                           DATA_WIDTH'(shadow[coef_idx]);
    PRDATA     = (PREADY && !PWRITE && !err) ? rdata : '0;
    coef_rdata = int'(coef_raddr) < NUM_COEF ? active[coef_raddr] : '0;
    unused     = ^{PWDATA, coef_off};
  end

  // A setup phase is accepted from any state, which covers back-to-back transfers out of DONE.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (PSEL && !PENABLE) begin
      state    <= WAIT;
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == WAIT) begin
      state    <= !PSEL ? IDLE : (PENABLE && wait_cnt == 4'd0) ? DONE : WAIT;
      wait_cnt <= (PSEL && PENABLE && wait_cnt != 4'd0) ? wait_cnt - 4'd1 : wait_cnt;
    end else
      state <= IDLE;

  // COMMIT is latched on the write edge and the bank copy happens one edge later.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      filt_en     <= 1'b0;
      bypass      <= 1'b0;
      coef_update <= 1'b0;
      commit_pend <= 1'b0;
      commit_cnt  <= '0;
      err_sticky  <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit_pend <= wr_ok && is_ctrl && PWDATA[2];
      coef_update <= commit_pend;
      commit_cnt  <= commit_pend ? commit_cnt + 8'd1 : commit_cnt;
      err_sticky  <= PSLVERR ? 1'b1 : (wr_ok && is_stat && PWDATA[8]) ? 1'b0 : err_sticky;
      if (wr_ok && is_ctrl) {bypass, filt_en} <= PWDATA[1:0];
      if (wr_ok && is_coef) shadow[coef_idx] <= PWDATA[COEF_W-1:0];
      if (commit_pend) active <= shadow;
    end
endmodule

// File: tb/tb_apb_cfg_slave.sv
// tb_apb_cfg_slave: directed APB transfers against apb_cfg_slave with hand-computed expectations.
module tb_apb_cfg_slave;
  logic PCLK = 0, PRESETn = 1, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [31:0] PADDR = 0, PWDATA = 0, PRDATA;
  logic PREADY, PSLVERR, filt_en, bypass, coef_update;
  logic [3:0] coef_raddr = 0;
  logic [15:0] coef_rdata;
  int errors = 0, checks = 0, upd_cnt = 0, u0 = 0, wt = 0;
  logic [31:0] rd;
  logic se;

  apb_cfg_slave dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .filt_en(filt_en), .bypass(bypass), .coef_raddr(coef_raddr), .coef_rdata(coef_rdata),
    .coef_update(coef_update)
  );

  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) if (PRESETn && coef_update) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts the setup phase at the current time, so consecutive calls are back-to-back.
  task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata);
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1 PENABLE = 1; wt = 0;
    while (!PREADY && wt < 20) begin @(posedge PCLK); #1 wt++; end
    chk("pready", {31'b0, PREADY}, 1);
    rd = PRDATA; se = PSLVERR;
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
  endtask

  task automatic wr_ok(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    xfer(1, addr, wdata);
    chk(tag, {31'b0, se}, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    xfer(0, addr, 0);
    chk(tag, rd, exp);
    chk("rd_slverr", {31'b0, se}, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #2 PRESETn = 0;
    #1;
    chk("rst_pready", {31'b0, PREADY}, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_outs", {27'b0, PSLVERR, filt_en, bypass, coef_update, 1'b0}, 0);
    chk("rst_coef", {16'b0, coef_rdata}, 0);
    idle(3);
    PRESETn = 1;
    idle(1);

    // single write/read with one wait state
    xfer(1, 32'h040, 32'h0000_1234);
    chk("w40_waits", wt, 1);
    chk("w40_slverr", {31'b0, se}, 0);
    xfer(0, 32'h040, 0);
    chk("r40_waits", wt, 1);
    chk("r40_data", rd, 32'h0000_1234);
    wr_ok("w44", 32'h044, 32'hFFFF_ABCD);
    rd_chk("r44_upper0", 32'h044, 32'h0000_ABCD);
    idle(1);

    // shadow load then commit
    coef_raddr = 4'd3;
    for (int i = 0; i < 16; i++) wr_ok("wcoef", 32'h040 + 4 * i, i + 1);
    idle(1);
    chk("coef_precommit", {16'b0, coef_rdata}, 0);
    u0 = upd_cnt;
    wr_ok("wctrl5", 32'h000, 32'h5);
    chk("en_write_edge", {31'b0, filt_en}, 1);
    chk("upd_e0", {31'b0, coef_update}, 0);
    chk("coef_e0", {16'b0, coef_rdata}, 0);
    idle(1);
    chk("upd_e1", {31'b0, coef_update}, 1);
    chk("coef_e1", {16'b0, coef_rdata}, 4);
    idle(1);
    chk("upd_e2", {31'b0, coef_update}, 0);
    chk("upd_once", upd_cnt - u0, 1);
    rd_chk("status_1", 32'h004, 32'h001);
    rd_chk("ctrl_commit0", 32'h000, 32'h001);
    wr_ok("w4c_shadow", 32'h04C, 32'h77);
    idle(2);
    chk("shadow_hidden", {16'b0, coef_rdata}, 4);
    rd_chk("r7c_last", 32'h07C, 32'h10);

    // error responses
    xfer(0, 32'h002, 0);
    chk("r002_err", {31'b0, se}, 1);
    chk("r002_data", rd, 0);
    xfer(1, 32'h100, 32'hFFFF);
    chk("w100_err", {31'b0, se}, 1);
    xfer(0, 32'h080, 0);
    chk("r080_err", {31'b0, se}, 1);
    xfer(1, 32'h1000, 32'h3);
    chk("whigh_err", {31'b0, se}, 1);
    rd_chk("ctrl_unchanged", 32'h000, 32'h001);
    rd_chk("status_sticky", 32'h004, 32'h101);
    wr_ok("wstat0", 32'h004, 32'h000);
    rd_chk("status_keep", 32'h004, 32'h101);
    wr_ok("wstat100", 32'h004, 32'h100);
    rd_chk("status_clr", 32'h004, 32'h001);

    // commit counter wrap
    for (int i = 0; i < 255; i++) wr_ok("wcommit", 32'h000, 32'h5);
    idle(3);
    chk("upd_256", upd_cnt, 256);
    rd_chk("status_wrap", 32'h004, 32'h000);
    chk("coef_after_wrap", {16'b0, coef_rdata}, 32'h77);

    // back-to-back write/read pairs
    wr_ok("b2b_w48", 32'h048, 32'hA5A5);
    rd_chk("b2b_r48", 32'h048, 32'hA5A5);
    chk("b2b_waits", wt, 1);
    wr_ok("b2b_w4c", 32'h04C, 32'h5A5A);
    rd_chk("b2b_r4c", 32'h04C, 32'h5A5A);
    wr_ok("b2b_wctrl", 32'h000, 32'h3);
    rd_chk("b2b_rctrl", 32'h000, 32'h3);
    chk("bypass_on", {31'b0, bypass}, 1);

    // abort before PREADY
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h050; PWDATA = 32'hDEAD;
    @(posedge PCLK); #1 PENABLE = 1;
    chk("abort_pready", {31'b0, PREADY}, 0);
    PSEL = 0; PENABLE = 0;
    idle(1);
    chk("abort_idle_pready", {31'b0, PREADY}, 0);
    rd_chk("abort_nowrite", 32'h050, 32'h5);

    // reset mid-WAIT
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h000; PWDATA = 32'h0;
    @(posedge PCLK); #1 PENABLE = 1;
    chk("mid_pready0", {31'b0, PREADY}, 0);
    PRESETn = 0;
    #1;
    chk("rst_mid_pready", {31'b0, PREADY}, 0);
    chk("rst_mid_regs", {29'b0, filt_en, bypass, coef_update}, 0);
    chk("rst_mid_coef", {16'b0, coef_rdata}, 0);
    @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    idle(1);
    PRESETn = 1;
    idle(1);
    rd_chk("post_ctrl", 32'h000, 0);
    rd_chk("post_status", 32'h004, 0);
    rd_chk("post_coef", 32'h048, 0);
    wr_ok("post_w40", 32'h040, 32'h1);
    rd_chk("post_r40", 32'h040, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
